// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_ADDR,
    ST_DATA,
    ST_CSUM,
    ST_RESP
  } state_e;

  localparam logic [7:0] SYNC_DEF = 8'h55;
  localparam logic [7:0] ACK_DEF  = 8'h06;
  localparam logic [7:0] NAK_DEF  = 8'h15;

  // COUNT plus four address bytes; SYNC is not counted.
  localparam int HDR_LEN    = 5;
  localparam int ADDR_BYTES = HDR_LEN - 1;

  // COUNT of zero encodes a full 256-word payload.
  function automatic logic [8:0] word_count(input logic [7:0] c);
    return (c == 8'd0) ? 9'd256 : {1'b0, c};
  endfunction

endpackage

// File: rtl/uart_loader_gap.sv
// Inter-byte gap timer: saturating 32-bit counter, cleared by kick or when disabled.
module byte_gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam logic [31:0] LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || kick)     cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + 32'd1;
  end

  // Fires on the cycle the count steps onto TIMEOUT_CYCLES, so it is a single pulse.
  assign expired = enable && !kick && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_loader.sv
// Framed UART program loader: parses SYNC/COUNT/ADDR/DATA/CSUM, writes words, answers ACK/NAK.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEF,
  parameter logic [7:0]  ACK_BYTE       = ACK_DEF,
  parameter logic [7:0]  NAK_BYTE       = NAK_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_e      state_q, state_d;
  logic [7:0]  csum_q, csum_d;
  logic [8:0]  wleft_q, wleft_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic        ack_q, ack_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        gap_en, expired;
  logic [7:0]  csum_add;

  assign gap_en   = (state_q == ST_COUNT) || (state_q == ST_ADDR) ||
                    (state_q == ST_DATA)  || (state_q == ST_CSUM);
  assign csum_add = csum_q + rx_byte;

  byte_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
    .clk     (clk),
    .rst     (rst),
    .enable  (gap_en),
    .kick    (rx_valid),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    csum_d      = csum_q;
    wleft_d     = wleft_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    word_d      = word_q;
    ack_d       = ack_q;
    tx_byte_d   = tx_byte_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tx_start    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_d = ST_COUNT;
          csum_d  = '0;
          idx_d   = '0;
        end
      end
      ST_COUNT: begin
        if (rx_valid) begin
          wleft_d = word_count(rx_byte);
          csum_d  = csum_add;
          idx_d   = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          csum_d = csum_add;
          addr_d = {rx_byte, addr_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'(ADDR_BYTES - 1)) begin
            addr_d[1:0] = 2'b00;
            state_d     = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          csum_d = csum_add;
          word_d = {rx_byte, word_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = {rx_byte, word_q[31:8]};
            addr_d      = addr_q + 32'd4;
            wleft_d     = wleft_q - 9'd1;
            if (wleft_q == 9'd1) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          csum_d    = csum_add;
          ack_d     = (csum_add == 8'd0);
          tx_byte_d = (csum_add == 8'd0) ? ACK_BYTE : NAK_BYTE;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        // Incoming bytes are deliberately ignored until the response is out.
        tx_start = tx_ready;
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // expired is gated by rx_valid inside the timer, so it never races a byte.
    if (expired) begin
      ack_d     = 1'b0;
      tx_byte_d = NAK_BYTE;
      state_d   = ST_RESP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      csum_q      <= '0;
      wleft_q     <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      ack_q       <= 1'b0;
      tx_byte_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      csum_q      <= csum_d;
      wleft_q     <= wleft_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      ack_q       <= ack_d;
      tx_byte_q   <= tx_byte_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign tx_byte   = tx_byte_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = tx_start && ack_q;
  assign error     = tx_start && !ack_q;

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: frames are modelled from the protocol rules and checked by a monitor.
module tb_uart_loader;

  localparam int T = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  uart_loader #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .tx_byte   (tx_byte),
    .tx_start  (tx_start),
    .tx_ready  (tx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_resp[$];
  int passed = 0, total = 0;
  int cyc = 0, last_rx_cyc = 0, resp_cyc = 0, n_resp = 0;
  int gap_max = 0;
  wr_t        mon_w;
  logic [7:0] mon_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, want);
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    total++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected writes/responses whenever the DUT presents one.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) last_rx_cyc = cyc;
      if (mem_we) begin
        if (exp_wr.size() == 0) fail("unexpected_write", {mem_addr, mem_wdata});
        else begin
          mon_w = exp_wr.pop_front();
          check("write", {mem_addr, mem_wdata}, {mon_w.a, mon_w.d});
        end
      end
      if (tx_start) begin
        resp_cyc = cyc;
        n_resp++;
        check("tx_ready_at_start", 64'(tx_ready), 64'd1);
        if (exp_resp.size() == 0) fail("unexpected_response", 64'(tx_byte));
        else begin
          mon_b = exp_resp.pop_front();
          check("tx_byte", 64'(tx_byte), 64'(mon_b));
          check("done_error", 64'({done, error}), (mon_b == 8'h06) ? 64'd2 : 64'd1);
        end
      end else if (done || error) begin
        fail("stray_done_error", 64'({done, error}));
      end
    end
  end

  task automatic put(input logic [7:0] b);
    int g;
    g = int'($urandom_range(gap_max, 0));
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (g) begin @(posedge clk); #1; end
  endtask

  // Reference model: expected writes and response derived from the frame rules.
  task automatic frame(input logic [7:0] cnt, input logic [31:0] base, input bit bad);
    int n;
    logic [7:0]  sum, cs;
    logic [31:0] w;
    wr_t e;
    n   = (cnt == 8'd0) ? 256 : int'(cnt);
    sum = cnt;
    put(8'h55);
    put(cnt);
    for (int i = 0; i < 4; i++) begin
      put(base[8*i +: 8]);
      sum = sum + base[8*i +: 8];
    end
    for (int i = 0; i < n; i++) begin
      w   = $urandom;
      e.a = (base & 32'hFFFF_FFFC) + 32'(4 * i);
      e.d = w;
      exp_wr.push_back(e);
      for (int k = 0; k < 4; k++) begin
        put(w[8*k +: 8]);
        sum = sum + w[8*k +: 8];
      end
    end
    cs = 8'd0 - sum;
    if (bad) cs = cs + 8'($urandom_range(255, 1));
    exp_resp.push_back(bad ? 8'h15 : 8'h06);
    put(cs);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_resp.size() != 0 || busy) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 4000) fail({name, "_drain_timeout"}, 64'(exp_wr.size() + exp_resp.size()));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f1 [11];
    int n0, n;
    f1 = '{8'h55, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB7};
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("reset_outputs", {tx_byte, tx_start, mem_we, mem_addr[22:0], busy, done, error}, 64'd0);
    check("reset_wdata", 64'({mem_addr, mem_wdata}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Good one-word frame
    exp_wr.push_back('{32'h0000_1000, 32'hDEAD_BEEF});
    exp_resp.push_back(8'h06);
    foreach (f1[i]) put(f1[i]);
    drain("good");

    // Bad checksum: write still lands, NAK
    exp_wr.push_back('{32'h0000_1000, 32'hDEAD_BEEF});
    exp_resp.push_back(8'h15);
    f1[10] = 8'hB8;
    foreach (f1[i]) put(f1[i]);
    drain("bad_csum");

    // Junk bytes, then a frame with the transmitter held busy
    put(8'h00); put(8'hFF); put(8'h13);
    tx_ready = 1'b0;
    n0 = n_resp;
    frame(8'd1, $urandom, 1'b0);
    repeat (500) @(posedge clk); #1;
    check("held_while_busy", 64'(n_resp - n0), 64'd0);
    check("resp_pending", 64'(exp_resp.size()), 64'd1);
    tx_ready = 1'b1;
    drain("busy_tx");
    check("one_response", 64'(n_resp - n0), 64'd1);

    // Timeout: partial header, then silence
    exp_resp.push_back(8'h15);
    n0 = n_resp;
    put(8'h55); put(8'h01); put(8'h00);
    n = 0;
    while (n_resp == n0 && n < T + 200) begin @(posedge clk); #1; n++; end
    if (n_resp == n0) fail("timeout_no_response", 64'(n));
    else check("timeout_latency", 64'(resp_cyc - last_rx_cyc), 64'(T + 1));
    check("busy_after_timeout", 64'(busy), 64'd0);
    frame(8'd2, $urandom, 1'b0);
    drain("after_timeout");

    // COUNT=0 with address wrap
    frame(8'd0, 32'hFFFF_FF00, 1'b0);
    drain("wrap");

    // Reset mid-DATA: no write and no response
    put(8'h55); put(8'h02);
    put(8'h40); put(8'h00); put(8'h00); put(8'h00);
    put(8'hAA); put(8'hBB);
    rst = 1'b1;
    #2;
    check("midreset_outputs", {tx_byte, tx_start, mem_we, mem_addr[22:0], busy, done, error}, 64'd0);
    check("midreset_wdata", 64'({mem_addr, mem_wdata}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    frame(8'd3, $urandom, 1'b0);
    drain("after_reset");

    // Randomized frames with back-to-back and gapped bytes
    for (int f = 0; f < 12; f++) begin
      gap_max = int'($urandom_range(3, 0));
      frame(8'($urandom_range(6, 1)), $urandom, ($urandom_range(3, 0) == 0));
      drain("random");
    end

    check("scoreboard_empty", 64'(exp_wr.size() + exp_resp.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
# uart_loader

Byte-level program loader sitting directly downstream of the RS232 receiver and upstream of its transmitter in the FPGA computer. It consumes received bytes (`RX`/`hasRX`), parses a framed load protocol, and issues 32-bit word writes into instruction/data memory. At the end of each frame it sends a one-byte ACK or NAK back through the transmitter (`TX`/`start_TX`/`TX_ready`).

## Interface
- `SYNC_BYTE`, default 8'h55: frame start marker.
- `ACK_BYTE`, default 8'h06: response for a good frame.
- `NAK_BYTE`, default 8'h15: response for a bad or timed-out frame.
- `TIMEOUT_CYCLES`, default 50_000_000: maximum gap between bytes inside a frame, in clk cycles (1 s at 50 MHz).
- `clk  in  1`: system clock. The block has one clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `rx_byte  in  8`: received byte; connect to the receiver's `RX`.
- `rx_valid  in  1`: one-cycle strobe; connect to `hasRX`. Cannot be stalled.
- `tx_byte  out  8`: byte to transmit; connect to `TX`.
- `tx_start  out  1`: transmit request; connect to `start_TX`.
- `tx_ready  in  1`: transmitter idle; connect to `TX_ready`.
- `mem_we  out  1`: one-cycle write strobe. Memory must accept the write in that cycle.
- `mem_addr  out  32`: byte address of the word being written, always 4-aligned.
- `mem_wdata  out  32`: write data.
- `busy  out  1`: high in every state except IDLE.
- `done  out  1`: one-cycle pulse when an ACK is issued.
- `error  out  1`: one-cycle pulse when a NAK is issued.

## Operation
- Frame format: SYNC, COUNT, ADDR0..ADDR3, then DATA bytes, then CSUM.
  - ADDR and each data word are little-endian.
  - DATA is 4×N bytes, where N = COUNT, and COUNT 0 means N = 256.
  - CSUM makes the 8-bit sum of every byte from COUNT through CSUM equal 0.
- The FSM has six states: IDLE, COUNT, ADDR, DATA, CSUM, RESP.
- IDLE:
  - A byte equal to SYNC_BYTE moves the FSM to COUNT and clears the checksum accumulator.
  - Any other byte is ignored.
- COUNT: latches N and moves to ADDR.
- ADDR:
  - Shifts in 4 bytes, then moves to DATA.
  - Base address bits [1:0] are forced to 0.
- DATA:
  - Assembles words. On the 4th byte of word i, issues a write with `mem_addr` = base + 4·i.
  - Address arithmetic is 32-bit and wraps modulo 2^32.
  - After word N-1 the FSM moves to CSUM.
- CSUM:
  - Adds the received byte to the accumulator.
  - Result 0 selects ACK; nonzero selects NAK. Either way the FSM moves to RESP.
  - Writes already issued are not rolled back.
- RESP:
  - Waits for `tx_ready`=1, then asserts `tx_start` for exactly one cycle with `tx_byte` valid, and returns to IDLE.
  - `rx_valid` in RESP is dropped.
- Timeout:
  - In COUNT, ADDR, DATA or CSUM, a gap counter resets on every `rx_valid`.
  - When it reaches TIMEOUT_CYCLES, the FSM selects NAK and moves to RESP.
- Reset mid-frame: all state is discarded, no response is sent, and the FSM enters IDLE.
- Reset values: `tx_byte`=0, `tx_start`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0.

## Timing
- `mem_we`:
  - Asserted in the cycle after the `rx_valid` of a word's 4th byte.
  - `mem_addr` and `mem_wdata` are valid in that cycle and held until the next write.
- Response:
  - `tx_start` rises at the earliest in the cycle after the CSUM byte's `rx_valid` (or after the timeout expiry cycle).
  - It is delayed while `tx_ready`=0.
  - `tx_byte` is set no later than the `tx_start` cycle and held until the next response.
- `done`/`error` pulse in the same cycle as `tx_start`.
- `tx_start` is never asserted while `tx_ready`=0.
- Back-to-back `rx_valid` on consecutive cycles must be handled. The receiver never produces this, but the bench will.
- Gap counter: 32 bits, saturating.

## Structure
- `uart_loader_pkg` holds:
  - the state enum
  - default SYNC/ACK/NAK constants
  - the frame header length (5 bytes)
- Sub-module `byte_gap_timer`:
  - Inputs: `clk`, `rst`, `enable`, `kick` (tied to `rx_valid`).
  - Output: `expired`, a one-cycle pulse.
  - Parameter: TIMEOUT_CYCLES.
- The FSM, word assembler and checksum accumulator live in `uart_loader`.

## Test plan
- **Good one-word frame:** 55 01 00 10 00 00 EF BE AD DE B7 → one `mem_we` with addr 0x00001000 and data 0xDEADBEEF; `tx_byte`=0x06 with `tx_start`; `done` pulse.
- **Bad checksum:** same frame with CSUM B8 → the write still occurs; `tx_byte`=0x15; `error` pulse; no `done`.
- **Junk and busy transmitter:** bytes 00 FF 13 before a valid frame are ignored; hold `tx_ready`=0 for 500 cycles → `tx_start` only after `tx_ready` rises; exactly one response.
- **Timeout:** TIMEOUT_CYCLES=1000; send 55 01 00, then stop → NAK exactly 1000 cycles after the last byte; `busy` falls; a following good frame is ACKed.
- **COUNT=0 and wrap:** COUNT=0 with base 0xFFFFFF00 → 256 writes with addresses FFFFFF00…FFFFFFFC, then 00000000…000002FC; ACK on correct CSUM.
- **Reset mid-DATA:** raise `rst` after 2 data bytes → no write, no response; outputs take their reset values; a following frame completes normally.
